reg_bank: RTL
=============

# reg_bank

Parametrised multi-register bank: the generalisation of the single write-enabled register into an array of `NUM_REGS` registers of `REG_WIDTH` bits, with one write port that also increments and decrements. Two combinational read ports, optional write-to-read bypass, per-register valid tracking and registered result flags. Sits in the CPU datapath to hold the index, stack and accumulator class registers, where load, increment and decrement are the common operations.

## Interface
- `REG_WIDTH`, 8, bits per register (≥2)
- `NUM_REGS`, 4, number of registers (2..16)
- `ADDR_WIDTH`, 2, address width; must satisfy 2^ADDR_WIDTH ≥ NUM_REGS
- `BYPASS`, 1, 1 = read ports forward the pending write result; 0 = read ports show the stored value
- `RESET_VAL`, 0, value loaded into every register on reset

Ports:
- `clk` in 1: sole clock, rising edge
- `reset_n` in 1: asynchronous active-low reset
- `op` in 2: 00 hold, 01 load `din`, 10 increment, 11 decrement
- `waddr` in ADDR_WIDTH: target register of `op`
- `din` in REG_WIDTH: load data
- `raddr_a` in ADDR_WIDTH: read port A address
- `raddr_b` in ADDR_WIDTH: read port B address
- `dout_a` out REG_WIDTH: read port A data
- `dout_b` out REG_WIDTH: read port B data
- `valid` out NUM_REGS: bit i set once register i has been targeted by any non-hold op since reset
- `zero` out 1: registered; last write result == 0
- `neg` out 1: registered; MSB of last write result
- `wrap` out 1: registered; last op was an increment from all-ones or a decrement from zero

## Operation
- Write result R: load → `din`; increment → reg+1 mod 2^REG_WIDTH; decrement → reg−1 mod 2^REG_WIDTH.
- Non-hold op with `waddr` < NUM_REGS:
  - register[waddr] ← R at the rising edge.
  - `valid[waddr]` ← 1.
  - `zero`/`neg`/`wrap` ← flags of R.
  - `wrap` is always 0 for a load.
- Hold op: nothing changes. Registers, `valid` and flags all keep their values.
- `waddr` ≥ NUM_REGS: op ignored entirely. No register, `valid` or flag update.
- Increment or decrement of a never-written register operates on RESET_VAL and sets its `valid` bit.
- Reads are combinational. `raddr` ≥ NUM_REGS returns 0.
- BYPASS=1 and a non-hold, in-range op with `raddr_x` == `waddr`: `dout_x` = R in the same cycle.
- BYPASS=0, or a hold op: `dout_x` = stored value.
- Both read ports are independent. They may address the same register or the write target simultaneously.
- `valid` bits never clear except on reset.

## Timing
- Reset (`reset_n` low, asynchronous, no clock needed):
  - all registers = RESET_VAL
  - `valid` = 0
  - `zero`, `neg`, `wrap` = 0
  - `dout_a`/`dout_b` follow the reset register contents immediately
- Reset deassertion: the first op is accepted at the first rising edge with `reset_n` high.
- Reset asserted mid-sequence: pending op discarded; state as above.
- Write latency: 1 cycle. The stored value is visible on the read ports (BYPASS=0) from the cycle after the edge.
- Flag latency: 1 cycle. Flags change on the same edge as the register.
- Bypass path: zero-cycle combinational from `op`/`waddr`/`din`/stored value to `dout_x`.
- Back-to-back ops on the same register: each cycle uses the value stored by the previous edge. Two increments in consecutive cycles yield +2.

## Test plan
- Reset, then load 0x5A to reg 1 → next cycle `dout_a`(raddr 1) = 0x5A, `valid` = 0b0010, zero=0, neg=0, wrap=0; other registers read 0x00.
- Load 0xFF to reg 2, then increment reg 2 → reg2 = 0x00, zero=1, wrap=1, neg=0. Then decrement → 0xFF, neg=1, wrap=1, zero=0.
- BYPASS=1: load 0x33 to reg 0 while `raddr_a`=0 and `raddr_b`=3 → same cycle `dout_a` = 0x33, `dout_b` = stored reg3. BYPASS=0 instance shows the old reg0 until the edge.
- NUM_REGS=3, ADDR_WIDTH=2: load 0x77 to `waddr` 3 → no state change, flags unchanged, `valid` unchanged; `raddr_a`=3 reads 0x00.
- Increment reg 3 for 4 consecutive cycles from reset (RESET_VAL=0) → reg3 = 0x04, `valid[3]`=1. Assert `reset_n` low asynchronously mid-cycle → reg3 = 0x00, `valid` = 0, flags = 0 without a clock edge.
- Hold for 5 cycles after a decrement of 0x00 → register and flags (wrap=1, neg=1) unchanged throughout.

Source files
------------

// File: rtl/reg_bank.sv
// Parametrised register bank: NUM_REGS x REG_WIDTH registers sharing one load/inc/dec write port,
// two combinational read ports with optional same-cycle bypass, per-register valid bits and result flags.
module reg_bank #(
   parameter int unsigned          REG_WIDTH  = 8,
   parameter int unsigned          NUM_REGS   = 4,
   parameter int unsigned          ADDR_WIDTH = 2,
   parameter bit                   BYPASS     = 1'b1,
   parameter logic [REG_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            op,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [REG_WIDTH-1:0]  din,
   input  logic [ADDR_WIDTH-1:0] raddr_a,
   input  logic [ADDR_WIDTH-1:0] raddr_b,
   output logic [REG_WIDTH-1:0]  dout_a,
   output logic [REG_WIDTH-1:0]  dout_b,
   output logic [NUM_REGS-1:0]   valid,
   output logic                  zero,
   output logic                  neg,
   output logic                  wrap
);

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_LOAD = 2'b01,
      OP_INC  = 2'b10,
      OP_DEC  = 2'b11
   } op_e;

   typedef struct packed {
      logic zero;
      logic neg;
      logic wrap;
   } flags_t;

   logic [REG_WIDTH-1:0]  regs_q [NUM_REGS];
   logic [REG_WIDTH-1:0]  regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]   valid_q, valid_d;
   flags_t                flags_q, flags_d;

   op_e                   op_cmd;
   logic [REG_WIDTH-1:0]  cur_val;
   logic [REG_WIDTH-1:0]  wr_result;
   logic                  wr_hit;
   logic                  wr_en;
   logic                  wr_wrap;

   logic [ADDR_WIDTH-1:0] raddr [2];
   logic [REG_WIDTH-1:0]  rdata [2];

   assign op_cmd = op_e'(op);

   // Write result; addresses with no backing register never raise wr_hit, so they are ignored.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can infer a latch.
      cur_val   = '0;
      wr_hit    = 1'b0;
      wr_result = '0;
      wr_wrap   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (waddr == ADDR_WIDTH'(i)) begin
            cur_val = regs_q[i];
            wr_hit  = 1'b1;
         end
      end
      wr_en = (op_cmd != OP_HOLD) && wr_hit;
      case (op_cmd)
         OP_LOAD: wr_result = din;
         OP_INC: begin
            wr_result = cur_val + REG_WIDTH'(1);
            wr_wrap   = (cur_val == '1);
         end
         OP_DEC: begin
            wr_result = cur_val - REG_WIDTH'(1);
            wr_wrap   = (cur_val == '0);
         end
         default: wr_result = cur_val;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      flags_d = flags_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_en && (waddr == ADDR_WIDTH'(i))) begin
            regs_d[i]  = wr_result;
            valid_d[i] = 1'b1;
         end
      end
      if (wr_en) begin
         flags_d.zero = (wr_result == '0);
         flags_d.neg  = wr_result[REG_WIDTH-1];
         flags_d.wrap = wr_wrap;
      end
   end

   assign raddr[0] = raddr_a;
   assign raddr[1] = raddr_b;

   // Read ports: unbacked addresses read 0; bypass only forwards an op that will actually commit.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr[p] == ADDR_WIDTH'(i)) rdata[p] = regs_q[i];
         end
         if (BYPASS && wr_en && (raddr[p] == waddr)) rdata[p] = wr_result;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the bank is reset flop by flop because every register must read RESET_VAL
         // straight out of reset; a RAM-style array would normally be left unreset.
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
         valid_q <= '0;
         flags_q <= '0;
      end else begin
         // NOTE: non-blocking, so every flop updates from the same pre-edge values.
         regs_q  <= regs_d;
         valid_q <= valid_d;
         flags_q <= flags_d;
      end
   end

   assign dout_a = rdata[0];
   assign dout_b = rdata[1];
   assign valid  = valid_q;
   assign zero   = flags_q.zero;
   assign neg    = flags_q.neg;
   assign wrap   = flags_q.wrap;

endmodule
